div_restoring_seq: RTL
======================

# div_restoring_seq

Sequential restoring unsigned divider for the synthesis library: it computes one quotient bit per clock using a single subtractor and iterates N times. It sits downstream of the library subtractor `SUB`, instantiating it once and consuming its difference and carry-out (no-borrow) each cycle. The divider serves as a compact, low-gate-count divide primitive for sequential garbled circuits, where one small datapath reused over N cycles is preferred to an unrolled array.

## Interface
- `N`, default 8: width of dividend, divisor, quotient and remainder; N >= 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `start`  in  1  request a division; accepted only in IDLE or DONE.
- `dividend`  in  N  unsigned dividend; sampled when `start` is accepted.
- `divisor`  in  N  unsigned divisor; sampled when `start` is accepted.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; results are valid from this cycle on.
- `quotient`  out  N  registered quotient.
- `remainder`  out  N  registered remainder.
- `div_by_zero`  out  1  registered; set with `done` when the divisor was 0.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE, `start`=1, divisor != 0:**
  - Load R=0, Q=`dividend`, D=`divisor`, cnt=N.
  - Next state RUN.
- **IDLE, `start`=1, divisor == 0:**
  - Load quotient = all ones, remainder = `dividend`, `div_by_zero`=1.
  - Next state DONE; RUN is skipped.
- **RUN, each cycle:**
  - Form T = {R, Q[N-1]}, which is N+1 bits.
  - Compute T - D using `SUB` #(N+1, N). D is zero-extended inside `SUB`.
  - CO=1 means no borrow. Then R = S[N-1:0] and Q = {Q[N-2:0], 1}.
  - CO=0 means borrow. Then R = T[N-1:0] and Q = {Q[N-2:0], 0}.
  - cnt decrements each cycle. When cnt reaches 1, the next state is DONE.
- **Width rule:** T is at most 2^(N+1)-2, so N+1 bits are required. After a successful subtract the result is always below D, so S[N] is always 0.
- **Entering DONE from RUN:**
  - quotient = Q, remainder = R, `div_by_zero`=0.
  - These are the final RUN-cycle values.
- **DONE:**
  - `done`=1 for exactly this one cycle.
  - If `start`=1, the request is handled as in IDLE (back-to-back operation). Otherwise go to IDLE.
- **Output holding:** `quotient`, `remainder` and `div_by_zero` hold their values until the next accepted `start` completes. They do not change during RUN.
- **`start` while in RUN:** ignored. Operands are not resampled.
- **Reset (`rst`=0 at an edge), at any time including mid-RUN:**
  - State = IDLE; `busy`, `done`, `div_by_zero` = 0; `quotient`, `remainder` = 0.
  - The in-flight division is discarded. `start` is ignored in the reset cycle.

## Timing
- `start` is sampled at edge k.
- **Nonzero divisor:**
  - `busy` is high in cycles k+1 through k+N.
  - `done` is high in cycle k+N+1.
  - Latency is N+1 cycles.
- **Zero divisor:** `done` is high in cycle k+1, and `busy` stays low.
- **Throughput:** with `start` held high in every DONE cycle, a new result arrives every N+1 cycles.
- **Output changes:** all outputs are registered. `quotient`, `remainder` and `div_by_zero` change only on the edge that enters DONE.
- **Combinational path:** the only combinational path is the single N+1-bit ripple subtract feeding the R/Q muxes. No input-to-output combinational path exists.

## Structure
- **Shared package `div_pkg`:**
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Counter width function clog2(N+1).
- **Sub-module:** exactly one instance, `SUB` #(.N(N+1), .M(N)). No other arithmetic sub-modules.
- **Counter:** the iteration counter is local to this module.

## Test plan
- **Basic divide:** N=8, dividend=100, divisor=7, `start` 1 cycle.
  - Required: `busy` high 8 cycles, then `done` one cycle later.
  - Result: quotient=14, remainder=2, `div_by_zero`=0.
- **Edge operands:**
  - dividend=255, divisor=1 gives quotient=255, remainder=0.
  - dividend=255, divisor=255 gives quotient=1, remainder=0.
  - dividend=5, divisor=9 gives quotient=0, remainder=5.
- **Divide by zero:** dividend=37, divisor=0.
  - Required: `done` at k+1 with no `busy`.
  - Result: quotient=8'hFF, remainder=37, `div_by_zero`=1.
  - Follow with 37/5: quotient=7, remainder=2, `div_by_zero` cleared.
- **Start during RUN:** start 200/3, then pulse `start` with 9/4 at cycle k+3.
  - Required: ignored; result is quotient=66, remainder=2 at k+9.
- **Back-to-back:** start 200/3, then hold `start` high in its DONE cycle with 50/6.
  - Required: second `done` 9 cycles later with quotient=8, remainder=2.
  - First result stays held until then.
- **Reset mid-operation:** assert `rst`=0 at cycle k+4 of 100/7.
  - Required: next cycle all outputs are 0 and the state is IDLE.
  - Then start 100/7 again and require quotient=14, remainder=2.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// the iteration-counter width helper.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold the value n itself, hence n+1 codes.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/div_restoring_seq_if.sv
// Request/result bundle of the sequential divider; master drives operands,
// slave (the divider) returns status and registered results.
interface div_restoring_seq_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/SUB.sv
// N-bit minus M-bit unsigned subtractor (b zero-extended); co=1 means no borrow.
module SUB #(
  parameter int N = 9,
  parameter int M = 8
) (
  input  logic [N-1:0] a,
  input  logic [M-1:0] b,
  output logic [N-1:0] s,
  output logic         co
);
  logic [N:0] diff;

  // One extra top bit captures the borrow of the N-bit subtraction.
  assign diff = {1'b0, a} - {{(N + 1 - M){1'b0}}, b};
  assign s    = diff[N-1:0];
  assign co   = ~diff[N];
endmodule

// File: rtl/div_restoring_seq.sv
// Restoring unsigned divider: one quotient bit per clock through a single
// shared subtractor, N iterations per division.
module div_restoring_seq
  import div_pkg::*;
#(
  parameter int N = 8
) (
  input logic               clk,
  input logic               rst,
  div_restoring_seq_if.slave bus
);
  localparam int CW = cnt_width(N);

  state_t        state_reg, state_next;
  logic [N-1:0]  r_reg, r_next;
  logic [N-1:0]  q_reg, q_next;
  logic [N-1:0]  d_reg, d_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [N-1:0]  quot_reg, quot_next;
  logic [N-1:0]  rem_reg, rem_next;
  logic          dbz_reg, dbz_next;

  logic [N:0]    t_val;
  logic [N:0]    sub_s;
  logic          sub_co;
  logic [N-1:0]  r_step;
  logic [N-1:0]  q_step;
  logic          unused_sub_msb;

  assign t_val = {r_reg, q_reg[N-1]};

  SUB #(.N(N + 1), .M(N)) u_sub (
    .a  (t_val),
    .b  (d_reg),
    .s  (sub_s),
    .co (sub_co)
  );

  // A successful subtract always leaves a value below D, so the top bit is 0.
  assign unused_sub_msb = sub_s[N];
  assign r_step = sub_co ? sub_s[N-1:0] : t_val[N-1:0];
  assign q_step = {q_reg[N-2:0], sub_co};

  always_comb begin
    state_next = state_reg;
    r_next     = r_reg;
    q_next     = q_reg;
    d_next     = d_reg;
    cnt_next   = cnt_reg;
    quot_next  = quot_reg;
    rem_next   = rem_reg;
    dbz_next   = dbz_reg;
    case (state_reg)
      IDLE, DONE: begin
        state_next = IDLE;
        if (bus.start) begin
          if (bus.divisor == '0) begin
            quot_next  = '1;
            rem_next   = bus.dividend;
            dbz_next   = 1'b1;
            state_next = DONE;
          end else begin
            r_next     = '0;
            q_next     = bus.dividend;
            d_next     = bus.divisor;
            cnt_next   = CW'(N);
            state_next = RUN;
          end
        end
      end
      RUN: begin
        r_next   = r_step;
        q_next   = q_step;
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          quot_next  = q_step;
          rem_next   = r_step;
          dbz_next   = 1'b0;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      r_reg     <= '0;
      q_reg     <= '0;
      d_reg     <= '0;
      cnt_reg   <= '0;
      quot_reg  <= '0;
      rem_reg   <= '0;
      dbz_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      r_reg     <= r_next;
      q_reg     <= q_next;
      d_reg     <= d_next;
      cnt_reg   <= cnt_next;
      quot_reg  <= quot_next;
      rem_reg   <= rem_next;
      dbz_reg   <= dbz_next;
    end
  end

  assign bus.busy        = (state_reg == RUN);
  assign bus.done        = (state_reg == DONE);
  assign bus.quotient    = quot_reg;
  assign bus.remainder   = rem_reg;
  assign bus.div_by_zero = dbz_reg;
endmodule
